// File: rtl/axi4_lite_bus_join_wr_if.sv
// AXI4-lite write-channel bundle (AW, W, B) for one initiator/target link.
//   master : the initiator side; drives AW/W and bready.
//   slave  : the target side; drives awready/wready and the B response.
interface axi4_lite_bus_join_wr_if #(
    parameter int A = 32,
    parameter int N = 4
);
    logic [A-1:0]   awaddr;
    logic           awvalid;
    logic           awready;
    logic [8*N-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_bus_join_wr.sv
// Two-initiator AXI4-lite write merger. Whole writes (AW+W together) are
// granted round-robin and forwarded one at a time; the owner of every
// forwarded write is queued in an in-order route FIFO so each downstream B
// response is steered back to the initiator that issued it.
//   aclk   : clock, rising edge
//   areset : synchronous active-high reset
//   s0, s1 : upstream initiator links (slave modport)
//   m      : downstream target link (master modport)
module axi4_lite_bus_join_wr #(
    parameter int A = 32,
    parameter int N = 4,
    parameter int D = 4
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi4_lite_bus_join_wr_if.slave       s0,
    axi4_lite_bus_join_wr_if.slave       s1,
    axi4_lite_bus_join_wr_if.master      m
);
    localparam int CW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t         state_q, state_d;
    logic           gnt_q, prio_q, aw_done_q, w_done_q;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic           route_q [D];

    logic           req0, req1, can_grant, pick;
    logic           aw_hs, w_hs, both_done, push, pop, head;
    logic [A-1:0]   awaddr_mux;
    logic [8*N-1:0] wdata_mux;
    logic [N-1:0]   wstrb_mux;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    // A port only competes once it shows both address and data.
    assign req0      = s0.awvalid & s0.wvalid;
    assign req1      = s1.awvalid & s1.wvalid;
    assign can_grant = (req0 | req1) && (count_q < CW'(D));
    // prio_q names the port that did not win the previous grant.
    assign pick      = (req0 & req1) ? prio_q : req1;

    assign aw_hs     = m.awvalid & m.awready;
    assign w_hs      = m.wvalid & m.wready;
    // Includes the cycle in which the last of the two handshakes lands.
    assign both_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign push      = (state_q == ISSUE) & both_done;
    assign pop       = m.bvalid & m.bready;
    assign head      = route_q[rd_ptr_q];

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_grant) state_d = ISSUE;
            ISSUE:   if (both_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, progress flags and route FIFO bookkeeping
    always_ff @(posedge aclk) begin
        if (areset) begin
            gnt_q     <= 1'b0;
            prio_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            if (state_q == IDLE && can_grant) gnt_q <= pick;
            if (push) begin
                prio_q    <= ~gnt_q;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                wr_ptr_q  <= ptr_inc(wr_ptr_q);
            end else if (state_q == ISSUE) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            // Push at count==D with a same-cycle pop is legal: the grant
            // was admitted while an entry was still free.
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) route_q[wr_ptr_q] <= gnt_q;
    end

    // Outputs: forward path from state/flops, B path steered by FIFO head.
    always_comb begin
        awaddr_mux = gnt_q ? s1.awaddr : s0.awaddr;
        wdata_mux  = gnt_q ? s1.wdata  : s0.wdata;
        wstrb_mux  = gnt_q ? s1.wstrb  : s0.wstrb;
        m.awaddr   = awaddr_mux;
        m.wdata    = wdata_mux;
        m.wstrb    = wstrb_mux;
        m.awvalid  = 1'b0;
        m.wvalid   = 1'b0;
        s0.awready = 1'b0;
        s0.wready  = 1'b0;
        s1.awready = 1'b0;
        s1.wready  = 1'b0;
        if (state_q == ISSUE) begin
            m.awvalid = ~aw_done_q;
            m.wvalid  = ~w_done_q;
            if (gnt_q) begin
                s1.awready = m.awready & ~aw_done_q;
                s1.wready  = m.wready & ~w_done_q;
            end else begin
                s0.awready = m.awready & ~aw_done_q;
                s0.wready  = m.wready & ~w_done_q;
            end
        end

        // With nothing outstanding a stray downstream B is never accepted.
        m.bready  = 1'b0;
        s0.bvalid = 1'b0;
        s0.bresp  = 2'b00;
        s1.bvalid = 1'b0;
        s1.bresp  = 2'b00;
        if (count_q != '0) begin
            if (head) begin
                m.bready  = s1.bready;
                s1.bvalid = m.bvalid;
                s1.bresp  = m.bresp;
            end else begin
                m.bready  = s0.bready;
                s0.bvalid = m.bvalid;
                s0.bresp  = m.bresp;
            end
        end
    end
endmodule
